// File: rtl/sdp_arb_pkg.sv
// Shared constants and helpers for the SDP round-robin arbiter.
package sdp_arb_pkg;

  localparam int unsigned MAX_NUM_REQ = 8;
  localparam int unsigned IDX_W       = $clog2(MAX_NUM_REQ);

  // A one-hot input ORs exactly one index into the result; all-zero yields 0.
  function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [MAX_NUM_REQ-1:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_NUM_REQ; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request at or above the pointer,
// wrapping, and moves the pointer just past the winner.
module rr_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0] mask, masked_req, pick;

  // Requests at or above the pointer win first; otherwise fall back to the
  // lowest request overall, which is the wrap-around case.
  assign mask       = ~((NUM_REQ'(1) << ptr_q) - NUM_REQ'(1));
  assign masked_req = req_i & mask;
  assign pick       = (|masked_req) ? masked_req : req_i;
  assign gnt_o      = pick & (~pick + NUM_REQ'(1));
  assign gnt_vld_o  = |req_i;
  assign gnt_idx_o  = onehot_to_idx(MAX_NUM_REQ'(gnt_o));

  // NOTE: every path through a combinational block assigns its outputs (here
  // via the default first), otherwise synthesis infers a latch.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_vld_o) begin
      ptr_d = (gnt_idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_o + IDX_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sdp_rr_arbiter.sv
// Shares one simple-dual-port target between NUM_REQ requesters with separate
// round-robin arbitration for the write and read ports.
module sdp_rr_arbiter
  import sdp_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_i,
  input  logic [NUM_REQ-1:0]            req_we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wd_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  output logic [NUM_REQ-1:0]            rvalid_o,
  output logic [DATA_WIDTH-1:0]         rdata_o,
  output logic [ADDR_WIDTH-1:0]         wa,
  output logic                          we,
  output logic [DATA_WIDTH-1:0]         wd,
  output logic [ADDR_WIDTH-1:0]         ra,
  output logic                          re,
  input  logic [DATA_WIDTH-1:0]         rd
);

  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [IDX_W-1:0]   wr_idx, rd_idx;
  logic               wr_vld, rd_vld;

  logic [ADDR_WIDTH-1:0] wa_q, wa_d, ra_q, ra_d;
  logic [DATA_WIDTH-1:0] wd_q, wd_d;
  logic                  we_q, re_q;
  logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;

  logic [RD_LATENCY-1:0]            pend_vld_q;
  logic [RD_LATENCY-1:0][IDX_W-1:0] pend_idx_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_wr_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i & req_we_i),
    .gnt_o     (wr_gnt),
    .gnt_idx_o (wr_idx),
    .gnt_vld_o (wr_vld)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rd_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i & ~req_we_i),
    .gnt_o     (rd_gnt),
    .gnt_idx_o (rd_idx),
    .gnt_vld_o (rd_vld)
  );

  assign gnt_o = wr_gnt | rd_gnt;

  // Address/data hold when their port is idle; only the enables drop.
  always_comb begin
    wa_d     = wa_q;
    wd_d     = wd_q;
    ra_d     = ra_q;
    rd_idx_d = rd_idx_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (wr_vld && wr_idx == IDX_W'(k)) begin
        wa_d = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        wd_d = req_wd_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
      if (rd_vld && rd_idx == IDX_W'(k)) begin
        ra_d     = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        rd_idx_d = rd_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wa_q     <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
      ra_q     <= '0;
      re_q     <= 1'b0;
      rd_idx_q <= '0;
    end else begin
      wa_q     <= wa_d;
      wd_q     <= wd_d;
      we_q     <= wr_vld;
      ra_q     <= ra_d;
      re_q     <= rd_vld;
      rd_idx_q <= rd_idx_d;
    end
  end

  // The pending pipeline starts at the registered re, so its last stage
  // lines up with rd arriving RD_LATENCY cycles later.
  // NOTE: this small register pipeline is reset (unlike a RAM array) so
  // reads in flight at reset never produce a stray rvalid_o afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= '0;
      pend_idx_q <= '0;
    end else begin
      pend_vld_q[0] <= re_q;
      pend_idx_q[0] <= rd_idx_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pend_vld_q[i] <= pend_vld_q[i-1];
        pend_idx_q[i] <= pend_idx_q[i-1];
      end
    end
  end

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    if (pend_vld_q[RD_LATENCY-1]) begin
      rvalid_o = NUM_REQ'(1) << pend_idx_q[RD_LATENCY-1];
      rdata_o  = rd;
    end
  end

  assign wa = wa_q;
  assign wd = wd_q;
  assign we = we_q;
  assign ra = ra_q;
  assign re = re_q;

endmodule

// File: tb/tb_sdp_rr_arbiter.sv
// Bench for sdp_rr_arbiter: two instances (RD_LATENCY 1 and 3) share stimulus;
// read returns are scoreboarded with their expected cycle.
module tb_sdp_rr_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 32;

  typedef struct {
    int            cyc;
    logic [N-1:0]  idx;
    logic [DW-1:0] data;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0]    req      = '0;
  logic [N-1:0]    req_we   = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wd   = '0;

  logic [N-1:0]  gnt1, rv1, gnt3, rv3;
  logic [DW-1:0] rdata1, wd1, rd1, rdata3, wd3, rd3;
  logic [AW-1:0] wa1, ra1, wa3, ra3;
  logic          we1, re1, we3, re3;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q1[$];
  exp_t q3[$];
  exp_t m1_e, m3_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sdp_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wd_i(req_wd), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rdata1), .wa(wa1), .we(we1),
    .wd(wd1), .ra(ra1), .re(re1), .rd(rd1)
  );

  sdp_rr_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_we_i(req_we), .req_addr_i(req_addr),
    .req_wd_i(req_wd), .gnt_o(gnt3), .rvalid_o(rv3), .rdata_o(rdata3), .wa(wa3), .we(we3),
    .wd(wd3), .ra(ra3), .re(re3), .rd(rd3)
  );

  // Target models: data = 0xA0 + address, garbage when not valid.
  logic          t1_vld = 1'b0;
  logic [AW-1:0] t1_a   = '0;
  logic [2:0]    t3_vld = '0;
  logic [2:0][AW-1:0] t3_a = '0;
  always @(posedge clk) begin
    t1_vld <= re1;
    t1_a   <= ra1;
    t3_vld <= {t3_vld[1:0], re3};
    t3_a   <= {t3_a[1:0], ra3};
  end
  assign rd1 = t1_vld    ? 32'hA0 + DW'(t1_a)    : 32'hDEAD_BEEF;
  assign rd3 = t3_vld[2] ? 32'hA0 + DW'(t3_a[2]) : 32'hDEAD_BEEF;

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (q1.size() != 0 && q1[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL rvalid1_missing cyc %0d idx %b never returned (due cyc %0d)", cyc, q1[0].idx, q1[0].cyc);
      void'(q1.pop_front());
    end
    checks++;
    if (rv1 != '0) begin
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL rvalid1_unexpected cyc %0d got rvalid %b rdata %h, required none", cyc, rv1, rdata1);
      end else begin
        m1_e = q1.pop_front();
        if (rv1 !== m1_e.idx || rdata1 !== m1_e.data || cyc != m1_e.cyc) begin
          errors++;
          $display("FAIL rvalid1 got idx %b data %h cyc %0d, required idx %b data %h cyc %0d",
                   rv1, rdata1, cyc, m1_e.idx, m1_e.data, m1_e.cyc);
        end
      end
    end else if (rdata1 !== '0) begin
      errors++;
      $display("FAIL rdata1_idle got %h required 0", rdata1);
    end
  end

  always @(negedge clk) begin
    if (q3.size() != 0 && q3[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL rvalid3_missing cyc %0d idx %b never returned (due cyc %0d)", cyc, q3[0].idx, q3[0].cyc);
      void'(q3.pop_front());
    end
    checks++;
    if (rv3 != '0) begin
      if (q3.size() == 0) begin
        errors++;
        $display("FAIL rvalid3_unexpected cyc %0d got rvalid %b rdata %h, required none", cyc, rv3, rdata3);
      end else begin
        m3_e = q3.pop_front();
        if (rv3 !== m3_e.idx || rdata3 !== m3_e.data || cyc != m3_e.cyc) begin
          errors++;
          $display("FAIL rvalid3 got idx %b data %h cyc %0d, required idx %b data %h cyc %0d",
                   rv3, rdata3, cyc, m3_e.idx, m3_e.data, m3_e.cyc);
        end
      end
    end else if (rdata3 !== '0) begin
      errors++;
      $display("FAIL rdata3_idle got %h required 0", rdata3);
    end
  end

  task automatic to_drive(); @(posedge clk); #1; endtask
  task automatic to_neg();   @(negedge clk);     endtask

  task automatic set_req(input int k, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k] = 1'b1;
    req_we[k] = w;
    req_addr[k*AW +: AW] = a;
    req_wd[k*DW +: DW] = d;
  endtask

  // Expected read return for a grant observed in cycle t.
  task automatic push_rd(input int t, input int k, input logic [AW-1:0] a);
    exp_t e;
    e.idx  = N'(1) << k;
    e.data = 32'hA0 + DW'(a);
    e.cyc  = t + 2;
    q1.push_back(e);
    e.cyc  = t + 4;
    q3.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && (q1.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    checks++;
    if (q1.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d/%0d reads outstanding, required 0/0", q1.size(), q3.size());
    end
  endtask

  task automatic do_reset();
    to_drive();
    rst_n = 1'b0;
    req = '0;
    req_we = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({gnt1, rv1, rdata1, wa1, we1, wd1, ra1, re1} !== '0) begin
      errors++;
      $display("FAIL %s dut1 got gnt %b rv %b rdata %h wa %h we %b wd %h ra %h re %b, required all 0",
               name, gnt1, rv1, rdata1, wa1, we1, wd1, ra1, re1);
    end
    checks++;
    if ({gnt3, rv3, rdata3, wa3, we3, wd3, ra3, re3} !== '0) begin
      errors++;
      $display("FAIL %s dut3 got gnt %b rv %b rdata %h wa %h we %b wd %h ra %h re %b, required all 0",
               name, gnt3, rv3, rdata3, wa3, we3, wd3, ra3, re3);
    end
  endtask

  task automatic test_reset();
    repeat (2) to_neg();
    check_all_zero("reset_state");
    rst_n = 1'b1;
  endtask

  // Runs directly after reset release: the first cycle's request is granted.
  task automatic test_single_read();
    int t;
    to_drive();
    set_req(2, 1'b0, 8'h05, '0);
    to_neg();
    t = cyc;
    checks++;
    if (gnt1 !== 4'b0100 || gnt3 !== 4'b0100) begin
      errors++;
      $display("FAIL single_gnt got %b/%b required 0100", gnt1, gnt3);
    end
    push_rd(t, 2, 8'h05);
    to_drive();
    req = '0;
    to_neg();
    checks++;
    if ({gnt1, re1, ra1, we1} !== {4'b0000, 1'b1, 8'h05, 1'b0}) begin
      errors++;
      $display("FAIL single_cmd got gnt %b re %b ra %h we %b, required 0000 1 05 0", gnt1, re1, ra1, we1);
    end
    drain();
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_g;
    do_reset();
    to_drive();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(8'h10 + k), '0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) to_drive();
      to_neg();
      exp_g = N'(1) << (i % N);
      checks++;
      if (gnt1 !== exp_g || gnt3 !== exp_g) begin
        errors++;
        $display("FAIL rr_gnt step %0d got %b/%b required %b", i, gnt1, gnt3, exp_g);
      end
      push_rd(cyc, i % N, AW'(8'h10 + i % N));
    end
    to_drive();
    req = '0;
    drain();
  endtask

  task automatic test_concurrent();
    do_reset();
    to_drive();
    set_req(0, 1'b1, 8'h01, 32'h11);
    set_req(2, 1'b0, 8'h03, '0);
    to_neg();
    checks++;
    if (gnt1 !== 4'b0101) begin
      errors++;
      $display("FAIL conc_gnt got %b required 0101", gnt1);
    end
    push_rd(cyc, 2, 8'h03);
    to_drive();
    req = '0;
    to_neg();
    checks++;
    if ({we1, wa1, wd1, re1, ra1} !== {1'b1, 8'h01, 32'h11, 1'b1, 8'h03}) begin
      errors++;
      $display("FAIL conc_cmd got we %b wa %h wd %h re %b ra %h, required 1 01 11 1 03", we1, wa1, wd1, re1, ra1);
    end
    to_drive();
    to_neg();
    checks++;
    if ({we1, wa1, wd1, re1} !== {1'b0, 8'h01, 32'h11, 1'b0}) begin
      errors++;
      $display("FAIL idle_hold got we %b wa %h wd %h re %b, required 0 01 11 0", we1, wa1, wd1, re1);
    end
    drain();
  endtask

  task automatic test_pointer_hold();
    do_reset();
    to_drive();
    set_req(1, 1'b1, 8'h21, 32'h1);
    to_neg();
    checks++;
    if (gnt1 !== 4'b0010) begin
      errors++;
      $display("FAIL hold_first got %b required 0010", gnt1);
    end
    to_drive();
    req = '0;
    repeat (2) to_drive();
    to_drive();
    set_req(0, 1'b1, 8'h20, 32'hA);
    set_req(2, 1'b1, 8'h22, 32'hC);
    to_neg();
    checks++;
    if (gnt1 !== 4'b0100 || gnt3 !== 4'b0100) begin
      errors++;
      $display("FAIL hold_ptr got %b/%b required 0100", gnt1, gnt3);
    end
    to_drive();
    req[2] = 1'b0;
    to_neg();
    checks++;
    if ({gnt1, we1, wa1, wd1} !== {4'b0001, 1'b1, 8'h22, 32'hC}) begin
      errors++;
      $display("FAIL hold_second got gnt %b we %b wa %h wd %h, required 0001 1 22 c", gnt1, we1, wa1, wd1);
    end
    to_drive();
    req = '0;
    to_neg();
    checks++;
    if ({we1, wa1, wd1} !== {1'b1, 8'h20, 32'hA}) begin
      errors++;
      $display("FAIL hold_wr0 got we %b wa %h wd %h, required 1 20 a", we1, wa1, wd1);
    end
  endtask

  task automatic test_back_to_back_lat3();
    int t;
    do_reset();
    to_drive();
    set_req(1, 1'b0, 8'h07, '0);
    to_neg();
    t = cyc;
    checks++;
    if (gnt3 !== 4'b0010) begin
      errors++;
      $display("FAIL b2b_gnt1 got %b required 0010", gnt3);
    end
    push_rd(t, 1, 8'h07);
    to_drive();
    req[1] = 1'b0;
    set_req(3, 1'b0, 8'h09, '0);
    to_neg();
    checks++;
    if (gnt3 !== 4'b1000) begin
      errors++;
      $display("FAIL b2b_gnt3 got %b required 1000", gnt3);
    end
    push_rd(t + 1, 3, 8'h09);
    to_drive();
    req = '0;
    drain();
  endtask

  task automatic test_reset_inflight();
    do_reset();
    to_drive();
    set_req(0, 1'b0, 8'h30, '0);
    to_neg();
    to_drive();
    req[0] = 1'b0;
    set_req(1, 1'b0, 8'h31, '0);
    to_neg();
    checks++;
    if (gnt1 !== 4'b0010) begin
      errors++;
      $display("FAIL inflight_gnt got %b required 0010", gnt1);
    end
    to_drive();
    req = '0;
    rst_n = 1'b0;
    to_neg();
    check_all_zero("inflight_reset_a");
    to_drive();
    to_neg();
    check_all_zero("inflight_reset_b");
    rst_n = 1'b1;
    to_drive();
    for (int k = 0; k < N; k++) set_req(k, 1'b0, AW'(8'h40 + k), '0);
    to_neg();
    checks++;
    if (gnt1 !== 4'b0001 || gnt3 !== 4'b0001) begin
      errors++;
      $display("FAIL post_reset_ptr got %b/%b required 0001", gnt1, gnt3);
    end
    push_rd(cyc, 0, 8'h40);
    to_drive();
    req = '0;
    drain();
    repeat (6) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_concurrent();
    test_pointer_hold();
    test_back_to_back_lat3();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sdp_rr_arbiter.md
# sdp_rr_arbiter

Shares one simple-dual-port (SDP) target, such as the GPIO register block or a small RAM, between NUM_REQ independent requesters. Two round-robin arbiters run in parallel, one for the write port and one for the read port, so one write and one read can issue in the same cycle. Granted commands are registered onto the SDP target port. Read data is routed back to the issuing requester after a fixed target read latency. The block sits between on-chip masters (bus bridges, DMA, debug) and any SDP-style peripheral.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 8, SDP address width
- DATA_WIDTH, 32, SDP data width
- RD_LATENCY, 1, cycles from re asserted at the target to valid rd (1..4)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NUM_REQ  per-requester request; held stable until granted
- req_we_i  in  NUM_REQ  1 = write, 0 = read, per requester
- req_addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester k at [k*ADDR_WIDTH +: ADDR_WIDTH]
- req_wd_i  in  NUM_REQ*DATA_WIDTH  packed write data
- gnt_o  out  NUM_REQ  one-hot-per-port pulse: request accepted this cycle
- rvalid_o  out  NUM_REQ  one-hot pulse: rdata_o belongs to this requester
- rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters
- wa  out  ADDR_WIDTH  target write address (registered)
- we  out  1  target write enable (registered)
- wd  out  DATA_WIDTH  target write data (registered)
- ra  out  ADDR_WIDTH  target read address (registered)
- re  out  1  target read enable (registered)
- rd  in  DATA_WIDTH  target read data, valid RD_LATENCY cycles after re

## Operation
- Write candidates: req_i & req_we_i. Read candidates: req_i & ~req_we_i. Each candidate set has its own round-robin arbiter.
- Each arbiter keeps a pointer wptr/rptr (reset 0). It grants the first candidate at index >= pointer, wrapping modulo NUM_REQ.
- On a grant, pointer <= granted index + 1 (mod NUM_REQ). With no grant, the pointer holds.
- gnt_o is combinational from req_i, req_we_i and the pointers. Write and read grants OR into gnt_o. A requester has only one type at a time, so gnt_o has at most 2 bits set.
- A requester still asserting req_i in the cycle after its grant is treated as a new request.
- Granted write: wa/wd/we <= the granted requester's addr/data/1 at the next edge. No write grant: we <= 0, and wa/wd hold.
- Granted read: ra/re <= addr/1 at the next edge. The requester index is pushed into a RD_LATENCY-deep pending pipeline (valid + index).
- Pipeline output valid: rvalid_o[index] = 1, rdata_o = rd (combinational pass-through, same cycle).
- Same-address write and read in one cycle: both are issued. The returned value follows the target's read-during-write semantics. The arbiter does not reorder or forward.
- The block sends no backpressure from the target. The target must accept one write and one read per cycle.

## Timing
- Reset values: gnt_o=0, rvalid_o=0, rdata_o=rd passthrough (0 when no valid), wa=0, we=0, wd=0, ra=0, re=0, both pointers 0, pending pipeline empty.
- Read: req at cycle t, gnt_o at t, re at t+1, rvalid_o at t+1+RD_LATENCY. Total 1+RD_LATENCY cycles.
- Write: gnt_o at t, we at t+1.
- Throughput: one read and one write per cycle in total. Under full contention, each requester gets a slot every NUM_REQ cycles per port.
- Reset mid-operation: pending reads are discarded, with no rvalid_o after reset deasserts. Pointers return to 0.
- rst_n deassertion: a request present in the first cycle after reset can be granted in that cycle.

## Structure
- Package sdp_arb_pkg: max NUM_REQ constant and a function onehot_to_idx.
- Sub-module rr_arbiter (NUM_REQ, req vector in, grant one-hot out, grant index out, pointer register), instantiated twice.
- The top level holds the command registers and the pending-read pipeline.

## Test plan
- Single read: NUM_REQ=4, RD_LATENCY=1. req_i=4'b0100, req_we_i=0, addr 8'h05, target returns 32'hA5 -> gnt_o=4'b0100 at t, re=1/ra=5 at t+1, rvalid_o=4'b0100 and rdata_o=32'hA5 at t+2.
- Round-robin reads: all four hold read requests for 8 cycles -> grant order 0,1,2,3,0,1,2,3. Each rvalid_o returns in the same order.
- Concurrent ports: req0 write (addr 1, data 32'h11) and req2 read (addr 3) in the same cycle -> gnt_o=4'b0101. we and re are both 1 at t+1.
- Pointer hold: grant to 1, then 3 idle cycles, then req 0 and 2 together -> grant 2 first (pointer=2), then 0.
- RD_LATENCY=3: back-to-back reads from req1, then req3 -> rvalid_o=0010 at t+4 and 1000 at t+5, with matching rdata_o.
- Reset with 2 reads in flight -> no rvalid_o after release. All outputs 0 and pointers 0 during reset.
